controlador_mul_ula: RTL and testbench

- Multi-cycle sequencer that performs unsigned BITS x BITS multiplication by shift-and-add.
- It borrows the shared ULA add/subtract datapath for one addition per iteration.
- It drives the ULA operand and control inputs while busy and signals ownership to the datapath mux.
- It produces the full 2*BITS product, used for MUL (low half) and MULHU (high half).

---
 rtl/controlador_mul_ula.sv | 122 ++++++++++++
 tb/tb_controlador_mul_ula.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_mul_ula.sv
// Shift-and-add unsigned BITS x BITS multiplier sequencer that borrows the shared ULA adder.
// Latency: start accepted at edge k, product valid (one-cycle valido pulse) after edge k+BITS.
// No backpressure: start is only accepted when idle; cancela aborts an in-progress multiply.
module controlador_mul_ula #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            cancela,
  input  logic [BITS-1:0] op_a,
  input  logic [BITS-1:0] op_b,
  output logic            ocupado,
  output logic            valido,
  output logic [BITS-1:0] produto_lo,
  output logic [BITS-1:0] produto_hi,
  output logic            ula_em_uso,
  output logic [BITS-1:0] ula_dina,
  output logic [BITS-1:0] ula_dinb,
  output logic [BITS-1:0] ula_imm,
  output logic            ula_usa_imm,
  output logic [1:0]      ula_soma_ou_subtrai,
  input  logic [BITS-1:0] ula_dout
);

  localparam int CW = $clog2(BITS) + 1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    PRONTO  = 2'd2
  } estado_t;

  estado_t         estado_q;
  logic [BITS-1:0] hi_q;
  logic [BITS-1:0] lo_q;
  logic [BITS-1:0] mcand_q;
  logic [BITS-1:0] prod_lo_q;
  logic [BITS-1:0] prod_hi_q;
  logic [CW-1:0]   contador_q;

  logic            em_calculo;
  logic            soma_sel;
  logic            carry;
  logic [BITS-1:0] parcial;
  logic [BITS-1:0] hi_d;
  logic [BITS-1:0] lo_d;
  logic            ultima_iter;

  // One iteration of shift-and-add; the ULA gives no carry, so it is recovered by an
  // unsigned wrap check (a sum smaller than an addend means the add overflowed).
  always_comb begin
    em_calculo  = (estado_q == CALCULA);
    soma_sel    = em_calculo & lo_q[0];
    carry       = soma_sel & (ula_dout < hi_q);
    parcial     = soma_sel ? ula_dout : hi_q;
    hi_d        = {carry, parcial[BITS-1:1]};
    lo_d        = {parcial[0], lo_q[BITS-1:1]};
    ultima_iter = (contador_q == CW'(BITS - 1));
  end

  // ULA drive is a pure decode of the current state so ula_dout settles within the same cycle.
  always_comb begin
    ula_em_uso          = em_calculo;
    ula_dina            = em_calculo ? hi_q : '0;
    ula_dinb            = em_calculo ? mcand_q : '0;
    ula_imm             = '0;
    ula_usa_imm         = 1'b0;
    ula_soma_ou_subtrai = soma_sel ? 2'd1 : 2'd0;
    ocupado             = (estado_q != OCIOSO);
    valido              = (estado_q == PRONTO);
    produto_lo          = prod_lo_q;
    produto_hi          = prod_hi_q;
  end

  // Sequencer: capture operands, iterate BITS times, publish the product for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      contador_q <= '0;
      prod_lo_q  <= '0;
      prod_hi_q  <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (start) begin
            mcand_q    <= op_a;
            lo_q       <= op_b;
            hi_q       <= '0;
            contador_q <= '0;
            estado_q   <= CALCULA;
          end
        end
        CALCULA: begin
          if (cancela) begin
            // Abort leaves the working registers untouched and the last product visible.
            estado_q <= OCIOSO;
          end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            contador_q <= contador_q + CW'(1);
            if (ultima_iter) begin
              prod_hi_q <= hi_d;
              prod_lo_q <= lo_d;
              estado_q  <= PRONTO;
            end
          end
        end
        PRONTO: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_mul_ula.sv
module tb_controlador_mul_ula;

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cancela = 1'b0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic        ocupado, valido, ula_em_uso, ula_usa_imm;
  logic [63:0] produto_lo, produto_hi, ula_dina, ula_dinb, ula_imm, ula_dout;
  logic [1:0]  ula_soma_ou_subtrai;

  logic        reset8 = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  op_a8 = '0;
  logic [7:0]  op_b8 = '0;
  logic        ocupado8, valido8, ula_em_uso8, ula_usa_imm8;
  logic [7:0]  produto_lo8, produto_hi8, ula_dina8, ula_dinb8, ula_imm8, ula_dout8;
  logic [1:0]  ula_soma_ou_subtrai8;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb64[$];
  exp_t sb8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared ULA: add / subtract / idle
  always_comb begin
    ula_dout = '0;
    if (ula_soma_ou_subtrai == 2'd1) ula_dout = ula_dina + ula_dinb;
    else if (ula_soma_ou_subtrai == 2'd2) ula_dout = ula_dina - ula_dinb;
    ula_dout8 = '0;
    if (ula_soma_ou_subtrai8 == 2'd1) ula_dout8 = ula_dina8 + ula_dinb8;
    else if (ula_soma_ou_subtrai8 == 2'd2) ula_dout8 = ula_dina8 - ula_dinb8;
  end

  controlador_mul_ula #(.BITS(64)) dut (
    .clk(clk), .reset(reset), .start(start), .cancela(cancela),
    .op_a(op_a), .op_b(op_b), .ocupado(ocupado), .valido(valido),
    .produto_lo(produto_lo), .produto_hi(produto_hi), .ula_em_uso(ula_em_uso),
    .ula_dina(ula_dina), .ula_dinb(ula_dinb), .ula_imm(ula_imm),
    .ula_usa_imm(ula_usa_imm), .ula_soma_ou_subtrai(ula_soma_ou_subtrai),
    .ula_dout(ula_dout)
  );

  controlador_mul_ula #(.BITS(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .cancela(1'b0),
    .op_a(op_a8), .op_b(op_b8), .ocupado(ocupado8), .valido(valido8),
    .produto_lo(produto_lo8), .produto_hi(produto_hi8), .ula_em_uso(ula_em_uso8),
    .ula_dina(ula_dina8), .ula_dinb(ula_dinb8), .ula_imm(ula_imm8),
    .ula_usa_imm(ula_usa_imm8), .ula_soma_ou_subtrai(ula_soma_ou_subtrai8),
    .ula_dout(ula_dout8)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop an expectation whenever a product is presented
  always @(negedge clk) begin : mon64
    exp_t e;
    if (valido) begin
      if (sb64.size() == 0) begin
        chk("unexpected_valido64", 1'b1, 1'b0);
      end else begin
        e = sb64.pop_front();
        chk("produto_lo64", produto_lo, e.lo);
        chk("produto_hi64", produto_hi, e.hi);
        chk("valido_cycle64", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (valido8) begin
      if (sb8.size() == 0) begin
        chk("unexpected_valido8", 1'b1, 1'b0);
      end else begin
        e = sb8.pop_front();
        chk("produto_lo8", produto_lo8, e.lo);
        chk("produto_hi8", produto_hi8, e.hi);
        chk("valido_cycle8", cyc, e.cyc);
      end
    end
  end

  // Pulse start for one edge; k is the edge at which the start is sampled
  task automatic go64(input logic [63:0] a, input logic [63:0] b, input logic canc, output int k);
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1; cancela = canc;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0; cancela = 1'b0;
  endtask

  task automatic push64(input logic [63:0] lo, input logic [63:0] hi, input int c);
    exp_t e;
    e.lo = lo; e.hi = hi; e.cyc = c;
    sb64.push_back(e);
  endtask

  task automatic wait_done64(input string nm);
    for (int i = 0; i < 300 && sb64.size() != 0; i++) @(negedge clk);
    chk(nm, sb64.size(), 0);
    sb64.delete();
    @(negedge clk);
  endtask

  initial begin
    int k;
    int nz;
    int em;
    exp_t e8;

    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_valido", valido, 1'b0);
    chk("rst_em_uso", ula_em_uso, 1'b0);
    chk("rst_produto", {produto_hi, produto_lo}, 128'd0);
    chk("rst_ula_ops", {ula_dina, ula_dinb, ula_imm}, 128'd0);
    chk("rst_ula_ctl", {ula_usa_imm, ula_soma_ou_subtrai}, 3'd0);
    chk("rst8_outs", {ocupado8, ula_em_uso8, ula_usa_imm8, ula_imm8}, 11'd0);
    reset = 1'b0; reset8 = 1'b0;

    // 3 x 5
    go64(64'd3, 64'd5, 1'b0, k);
    push64(64'd15, 64'd0, k + 64);
    wait_done64("timeout_3x5");
    chk("ocupado_after_valido", ocupado, 1'b0);

    // all ones: carry path
    go64('1, '1, 1'b0, k);
    push64(64'd1, 64'hFFFF_FFFF_FFFF_FFFE, k + 64);
    wait_done64("timeout_max");

    // zero multiplier: never adds, still full length
    go64(64'h1234, 64'd0, 1'b0, k);
    push64(64'd0, 64'd0, k + 64);
    nz = 0; em = 0;
    for (int i = 0; i < 64; i++) begin
      if (ula_soma_ou_subtrai != 2'd0) nz++;
      if (ula_em_uso) em++;
      @(negedge clk);
    end
    chk("zero_op_soma_cycles", nz, 0);
    chk("zero_op_em_uso_cycles", em, 64);
    wait_done64("timeout_zero");

    // start while busy is ignored
    go64(64'd7, 64'd6, 1'b0, k);
    push64(64'd42, 64'd0, k + 64);
    repeat (9) @(negedge clk);
    op_a = 64'd9; op_b = 64'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done64("timeout_busy_start");
    repeat (70) @(negedge clk);
    chk("busy_start_idle", ocupado, 1'b0);

    // reset mid-calculation
    go64(64'd3, 64'd5, 1'b0, k);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ocupado", ocupado, 1'b0);
    chk("midrst_em_uso", ula_em_uso, 1'b0);
    chk("midrst_produto", {produto_hi, produto_lo}, 128'd0);
    reset = 1'b0;

    // cancel mid-calculation keeps the previous product
    go64(64'd3, 64'd5, 1'b0, k);
    push64(64'd15, 64'd0, k + 64);
    wait_done64("timeout_pre_cancel");
    go64(64'd10, 64'd10, 1'b0, k);
    repeat (29) @(negedge clk);
    cancela = 1'b1;
    @(negedge clk);
    cancela = 1'b0;
    chk("cancel_ocupado", ocupado, 1'b0);
    chk("cancel_produto_kept", {produto_hi, produto_lo}, 128'd15);
    // immediate restart with cancela also high: start wins in OCIOSO
    go64(64'd2, 64'd2, 1'b1, k);
    push64(64'd4, 64'd0, k + 64);
    wait_done64("timeout_after_cancel");

    // BITS=8: 200 x 200 = 40000 = 0x9C40
    @(negedge clk);
    op_a8 = 8'd200; op_b8 = 8'd200; start8 = 1'b1;
    e8.lo = 64'h40; e8.hi = 64'h9C; e8.cyc = cyc + 1 + 8;
    sb8.push_back(e8);
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 40 && sb8.size() != 0; i++) @(negedge clk);
    chk("timeout_bits8", sb8.size(), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
